// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and forwarding controller for a 5-stage pipelined CPU datapath.
//   Shadows the destination/control fields of the instructions in EX and MEM,
//   drives the decode-stage forwarding mux selects, detects load-use and
//   flag-use hazards (stall PC/IF-ID, bubble ID/EX), flushes IF/ID on taken
//   branches resolved in decode, and counts stall/flush cycles (saturating).
//
// Ports:
//   clk, reset        clock (posedge) and asynchronous active-low reset
//   id_*              decode-stage instruction fields
//   forward_sel_a/b   00 regfile, 01 EX ALU result, 10 MEM write-back value
//   stall             hold PC and IF/ID
//   id_ex_bubble      zero write enables entering ID/EX
//   if_id_flush       discard the instruction currently in IF
//   stall_count       saturating count of stall cycles
//   flush_count       saturating count of flush cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_flag_set,
    input  logic             id_uses_flags,
    input  logic             id_branch_taken,
    output logic [1:0]       forward_sel_a,
    output logic [1:0]       forward_sel_b,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A slot is a forward source only if it holds a real register write to a
    // non-zero register; stores (reg_write=0) and bubbles never match.
    function automatic logic slot_hit(input logic             valid,
                                      input logic             reg_write,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] r);
        return valid & reg_write & (rd == r) & (r != ZERO_IDX);
    endfunction

    // Younger (EX) result wins over MEM when both slots match.
    function automatic logic [1:0] fwd_sel(input logic uses,
                                           input logic ex_hit,
                                           input logic mem_hit);
        logic [1:0] sel;
        if (!uses) begin
            sel = 2'b00;
        end else if (ex_hit) begin
            sel = 2'b01;
        end else if (mem_hit) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Shadow slots and counters
    logic             ex_valid_q,     ex_valid_d;
    logic [REG_W-1:0] ex_rd_q,        ex_rd_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q,  ex_mem_read_d;
    logic             ex_flag_set_q,  ex_flag_set_d;
    logic             mem_valid_q,     mem_valid_d;
    logic [REG_W-1:0] mem_rd_q,        mem_rd_d;
    logic             mem_reg_write_q, mem_reg_write_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Combinational hazard terms
    logic ex_hit_rn_s, ex_hit_rm_s, mem_hit_rn_s, mem_hit_rm_s;
    logic load_use_s, flag_stall_s, stall_s, flush_s;

    // Slot matches, hazard detection and forward selects from ID + shadow state
    always_comb begin
        ex_hit_rn_s  = slot_hit(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  id_rn);
        ex_hit_rm_s  = slot_hit(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  id_rm);
        mem_hit_rn_s = slot_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rn);
        mem_hit_rm_s = slot_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rm);

        // Load result is not available until the load reaches MEM.
        load_use_s   = id_valid & ex_mem_read_q &
                       ((ex_hit_rn_s & id_uses_rn) | (ex_hit_rm_s & id_uses_rm));
        // Flags are written at the end of EX, so a consumer waits one cycle.
        flag_stall_s = id_valid & id_uses_flags & ex_valid_q & ex_flag_set_q;
        stall_s      = load_use_s | flag_stall_s;
        // A stalled branch is re-evaluated next cycle, so it must not flush yet.
        flush_s      = id_valid & id_branch_taken & ~stall_s;

        forward_sel_a = fwd_sel(id_uses_rn, ex_hit_rn_s, mem_hit_rn_s);
        forward_sel_b = fwd_sel(id_uses_rm, ex_hit_rm_s, mem_hit_rm_s);
        stall         = stall_s;
        id_ex_bubble  = stall_s;
        if_id_flush   = flush_s;
    end

    // Next state: advance the shadow pipeline and bump saturating counters
    always_comb begin
        mem_valid_d     = ex_valid_q;
        mem_rd_d        = ex_rd_q;
        mem_reg_write_d = ex_reg_write_q;

        if (id_valid && !stall_s) begin
            ex_valid_d     = 1'b1;
            ex_rd_d        = id_rd;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
            ex_flag_set_d  = id_flag_set;
        end else begin
            ex_valid_d     = 1'b0;
            ex_rd_d        = {REG_W{1'b0}};
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_flag_set_d  = 1'b0;
        end

        if (stall_s && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end

        if (flush_s && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= {REG_W{1'b0}};
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_flag_set_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= {REG_W{1'b0}};
            mem_reg_write_q <= 1'b0;
            stall_count_q   <= {CNT_W{1'b0}};
            flush_count_q   <= {CNT_W{1'b0}};
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_flag_set_q   <= ex_flag_set_d;
            mem_valid_q     <= mem_valid_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            stall_count_q   <= stall_count_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios followed by random traffic. A reference model keeps
//   the last two issued instructions as records and derives expected
//   forwarding, stall, flush and counter values from them. A second instance
//   with narrow counters exercises counter saturation in few cycles.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fs;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rn = 5'd0, id_rm = 5'd0, id_rd = 5'd0;
    logic       id_uses_rn = 1'b0, id_uses_rm = 1'b0, id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0, id_flag_set = 1'b0, id_uses_flags = 1'b0;
    logic       id_branch_taken = 1'b0;

    logic [1:0]  forward_sel_a, forward_sel_b;
    logic        stall, id_ex_bubble, if_id_flush;
    logic [15:0] stall_count, flush_count;

    logic [1:0]  s_sel_a, s_sel_b;
    logic        s_stall, s_bubble, s_flush;
    logic [5:0]  s_stall_count, s_flush_count;

    int checks = 0;
    int failures = 0;

    // Reference model: hist[0] = instruction in EX, hist[1] = in MEM
    instr_t hist [0:1];
    int     tot_stall = 0;
    int     tot_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_flag_set(id_flag_set),
        .id_uses_flags(id_uses_flags), .id_branch_taken(id_branch_taken),
        .forward_sel_a(forward_sel_a), .forward_sel_b(forward_sel_b), .stall(stall),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_hazard_ctrl #(.CNT_W(6)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_flag_set(id_flag_set),
        .id_uses_flags(id_uses_flags), .id_branch_taken(id_branch_taken),
        .forward_sel_a(s_sel_a), .forward_sel_b(s_sel_b), .stall(s_stall),
        .id_ex_bubble(s_bubble), .if_id_flush(s_flush),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(input instr_t i, input logic [4:0] r);
        return i.v && i.rw && (i.rd == r) && (r != 5'd31);
    endfunction

    function automatic logic [1:0] exp_sel(input bit uses, input logic [4:0] r);
        if (!uses)                return 2'b00;
        if (writes(hist[0], r))   return 2'b01;
        if (writes(hist[1], r))   return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        hist[0] = '0;
        hist[1] = '0;
        tot_stall = 0;
        tot_flush = 0;
    endtask

    task automatic set_id(input bit v, input int rn, input int rm, input bit urn, input bit urm,
                          input int rd, input bit rw, input bit mr, input bit fs,
                          input bit uf, input bit bt);
        id_valid = v; id_rn = 5'(rn); id_rm = 5'(rm); id_uses_rn = urn; id_uses_rm = urm;
        id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr; id_flag_set = fs;
        id_uses_flags = uf; id_branch_taken = bt;
    endtask

    // One clock: compare every output with the model at negedge, then advance
    task automatic step();
        bit e_stall, e_flush;
        instr_t nxt;
        @(negedge clk);
        e_stall = (id_valid && hist[0].mr &&
                   ((writes(hist[0], id_rn) && id_uses_rn) || (writes(hist[0], id_rm) && id_uses_rm)))
                  || (id_valid && id_uses_flags && hist[0].v && hist[0].fs);
        e_flush = id_valid && id_branch_taken && !e_stall;
        chk("sel_a",  32'(forward_sel_a), 32'(exp_sel(id_uses_rn, id_rn)));
        chk("sel_b",  32'(forward_sel_b), 32'(exp_sel(id_uses_rm, id_rm)));
        chk("stall",  32'(stall),         32'(e_stall));
        chk("bubble", 32'(id_ex_bubble),  32'(e_stall));
        chk("flush",  32'(if_id_flush),   32'(e_flush));
        chk("stall_cnt",   32'(stall_count),   32'(sat(tot_stall, 65535)));
        chk("flush_cnt",   32'(flush_count),   32'(sat(tot_flush, 65535)));
        chk("s_stall_cnt", 32'(s_stall_count), 32'(sat(tot_stall, 63)));
        chk("s_flush_cnt", 32'(s_flush_count), 32'(sat(tot_flush, 63)));
        if (e_stall) tot_stall++;
        if (e_flush) tot_flush++;
        nxt = '0;
        if (id_valid && !e_stall) begin
            nxt.v = 1'b1; nxt.rd = id_rd; nxt.rw = id_reg_write;
            nxt.mr = id_mem_read; nxt.fs = id_flag_set;
        end
        hist[1] = hist[0];
        hist[0] = nxt;
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_reg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 31 : r;
    endfunction

    initial begin
        model_reset();
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1. async reset while EX holds a load to X3 and ID reads X3
        set_id(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0); step();           // LDUR X3
        set_id(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0);                  // reads X3
        #2;
        chk("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_sel_a", 32'(forward_sel_a), 32'd0);
        chk("rst_cnt",   32'(stall_count), 32'd0);
        chk("rst_flush", 32'(if_id_flush), 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sel_a", 32'(forward_sel_a), 32'd0);
        step();

        // 2. ADDI X1,X31,#2 ; ADDS X3,X1,X1 ; dependent on X1
        set_id(1, 31, 0, 1, 0, 1, 1, 0, 0, 0, 0); step();
        set_id(1, 1, 1, 1, 1, 3, 1, 0, 1, 0, 0); #2;
        chk("ex_fwd_a", 32'(forward_sel_a), 32'd1);
        chk("ex_fwd_b", 32'(forward_sel_b), 32'd1);
        step();
        set_id(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("mem_fwd_a", 32'(forward_sel_a), 32'd2);
        step();

        // 3. LDUR X5,[X1,#6] ; ADDI X5,X5,#0
        set_id(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0); step();
        set_id(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0); #2;
        chk("lu_stall",  32'(stall), 32'd1);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        step();
        #2;
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_fwd_a",   32'(forward_sel_a), 32'd2);
        chk("lu_cnt",     32'(stall_count), 32'd1);
        step();

        // 4. SUBS X3,X1,X2 ; B.cond taken
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); #2;
        chk("fl_stall", 32'(stall), 32'd1);
        chk("fl_noflush", 32'(if_id_flush), 32'd0);
        step();
        #2;
        chk("br_flush", 32'(if_id_flush), 32'd1);
        chk("br_nostall", 32'(stall), 32'd0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("br_flush_once", 32'(if_id_flush), 32'd0);
        chk("br_flush_cnt",  32'(flush_count), 32'd1);
        step();

        // 5. X31 never forwards or hazards; EX beats MEM on X2
        set_id(1, 1, 0, 1, 0, 31, 1, 1, 0, 0, 0); step();
        set_id(1, 31, 31, 1, 1, 6, 1, 0, 0, 0, 0); #2;
        chk("zr_sel_a", 32'(forward_sel_a), 32'd0);
        chk("zr_sel_b", 32'(forward_sel_b), 32'd0);
        chk("zr_stall", 32'(stall), 32'd0);
        step();
        set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); step();
        set_id(1, 0, 2, 0, 1, 7, 1, 0, 0, 0, 0); #2;
        chk("ex_over_mem_b", 32'(forward_sel_b), 32'd1);
        step();

        // 6. Drive 2^6+6 load-use stalls: narrow counter saturates
        for (int i = 0; i < 70; i++) begin
            set_id(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0); step();
            set_id(1, 0, 5, 0, 1, 8, 1, 0, 0, 0, 0); step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        chk("sat_small", 32'(s_stall_count), 32'h3F);
        chk("sat_wide",  32'(stall_count), 32'd72);
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            set_id(($urandom_range(0, 7) != 0), rnd_reg(), rnd_reg(),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   rnd_reg(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
